// File: rtl/pi_shift_ctrl_pkg.sv
// Shared types and constants for the Pi -> CPLD shift-register sequencer.
package pi_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Target register indices on the select bus (Pi -> TI side).
    localparam int unsigned REG_IDX_DATA = 0;
    localparam int unsigned REG_IDX_CTRL = 1;

endpackage

// File: rtl/pi_shift_ctrl_sync.sv
// Multi-flop synchronizer with optional armed rising-edge detection.
// EDGE_EN=1: o_q is a one-cycle rising-edge pulse per bit (masked until armed).
// EDGE_EN=0: o_q is the plain synchronized level.
module sync_edge
    import pi_shift_ctrl_pkg::*;
#(
    parameter int unsigned W       = 1,
    parameter int unsigned STAGES  = DEF_SYNC_STAGES,
    parameter bit          EDGE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_arm,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_chain [STAGES];
    logic [W-1:0] r_hist;
    logic [W-1:0] w_sync;
    logic [W-1:0] w_rise;

    // Synchronizer chain plus edge history; history always follows the
    // synchronized value so a line high at arming time yields no edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_hist <= w_sync;
        end
    end

    assign w_sync = r_chain[STAGES-1];
    assign w_rise = i_arm ? (w_sync & ~r_hist) : '0;
    assign o_q    = EDGE_EN ? w_rise : w_sync;

endmodule

// File: rtl/pi_shift_ctrl.sv
// Sequencer for the Pi GPIO serial-in/parallel-out register bank: turns the
// asynchronous Pi serial clock/data/latch/select into one-cycle shift and
// latch enables for the selected target, enforcing exact WIDTH-bit frames.
module pi_shift_ctrl
    import pi_shift_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 2,
    parameter int unsigned SEL_W       = 1,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pi_sclk,
    input  logic                pi_sdata,
    input  logic                pi_sle,
    input  logic [SEL_W-1:0]    pi_rsel,
    output logic                sh_din,
    output logic [NUM_REGS-1:0] sh_en,
    output logic [NUM_REGS-1:0] le,
    output logic                busy,
    output logic                frame_err,
    input  logic                clr_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WIDTH + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            v[i] = (32'(sel) == i);
        end
        return v;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                r_bad;
    logic                w_bad_nxt;
    logic [NUM_REGS-1:0] r_sh_en;
    logic [NUM_REGS-1:0] w_sh_en_nxt;
    logic                r_din;
    logic                r_err;
    logic                w_err_set;
    logic [ARM_W-1:0]    r_arm_cnt;
    logic                w_arm;
    logic                w_sclk_rise;
    logic                w_sle_rise;
    logic                w_sdata_s;
    logic [SEL_W-1:0]    w_rsel_s;
    logic                w_latch_ok;

    // Hold off edge detection until the synchronizers have refilled after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != ARM_DONE) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    assign w_arm = (r_arm_cnt == ARM_DONE);

    sync_edge #(
        .W       (2),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_sync_edges (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_arm   (w_arm),
        .i_async ({pi_sle, pi_sclk}),
        .o_q     ({w_sle_rise, w_sclk_rise})
    );

    sync_edge #(
        .W       (SEL_W + 1),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_sync_levels (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_arm   (w_arm),
        .i_async ({pi_rsel, pi_sdata}),
        .o_q     ({w_rsel_s, w_sdata_s})
    );

    assign w_latch_ok = (r_state == ST_LATCH) && (r_cnt == CNT_FULL) && !r_bad
                        && (32'(r_sel) < NUM_REGS);

    // Frame FSM next-state, counters and shift-enable decode.
    // A latch coinciding with a clock edge wins: the bit is dropped and the
    // frame is forced bad so the LATCH check rejects it regardless of count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_bad_nxt   = r_bad;
        w_sh_en_nxt = '0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sle_rise) begin
                    w_err_set = 1'b1;
                end else if (w_sclk_rise) begin
                    w_sel_nxt   = w_rsel_s;
                    w_cnt_nxt   = CNT_ONE;
                    w_bad_nxt   = 1'b0;
                    w_sh_en_nxt = f_onehot(w_rsel_s);
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_sle_rise) begin
                    if (w_sclk_rise) begin
                        w_bad_nxt = 1'b1;
                    end
                    w_state_nxt = ST_LATCH;
                end else if (w_sclk_rise) begin
                    if (r_cnt < CNT_FULL) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        w_cnt_nxt = CNT_OVER;
                        w_bad_nxt = 1'b1;
                    end
                    w_sh_en_nxt = f_onehot(r_sel);
                end
            end
            ST_LATCH: begin
                if (!w_latch_ok) begin
                    w_err_set = 1'b1;
                end
                w_cnt_nxt   = '0;
                w_bad_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, frame bookkeeping and registered shift outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_bad   <= 1'b0;
            r_sh_en <= '0;
            r_din   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_bad   <= w_bad_nxt;
            r_sh_en <= w_sh_en_nxt;
            if (w_sclk_rise) begin
                r_din <= w_sdata_s;
            end
        end
    end

    // Sticky framing error; a new error takes priority over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign sh_din    = r_din;
    assign sh_en     = r_sh_en;
    assign le        = w_latch_ok ? f_onehot(r_sel) : '0;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_err;

endmodule

// File: tb/tb_pi_shift_ctrl.sv
// Directed bench for pi_shift_ctrl: table of frames plus hand sequences for
// reset-mid-frame, latency and clear/set collision.
module tb_pi_shift_ctrl;
    import pi_shift_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pi_sclk = 1'b0;
    logic       pi_sdata = 1'b0;
    logic       pi_sle = 1'b0;
    logic [0:0] pi_rsel = 1'b0;
    logic       sh_din;
    logic [1:0] sh_en;
    logic [1:0] le;
    logic       busy;
    logic       frame_err;
    logic       clr_err = 1'b0;

    pi_shift_ctrl #(
        .NUM_REGS    (2),
        .SEL_W       (1),
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pi_sclk   (pi_sclk),
        .pi_sdata  (pi_sdata),
        .pi_sle    (pi_sle),
        .pi_rsel   (pi_rsel),
        .sh_din    (sh_din),
        .sh_en     (sh_en),
        .le        (le),
        .busy      (busy),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Output monitor: pulse counters, shifted-bit history, exclusion violations.
    int          n_sh0  = 0;
    int          n_sh1  = 0;
    int          n_le0  = 0;
    int          n_le1  = 0;
    int          n_excl = 0;
    logic [15:0] rec    = '0;

    always @(negedge clk) begin
        if (sh_en[0]) n_sh0++;
        if (sh_en[1]) n_sh1++;
        if (le[0]) n_le0++;
        if (le[1]) n_le1++;
        if (sh_en != 2'b00) rec = {rec[14:0], sh_din};
        if ((sh_en != 2'b00 && le != 2'b00) || $countones(sh_en) > 1 || $countones(le) > 1)
            n_excl++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pi_sdata = b;
        pi_sclk  = 1'b1;
        wait_cyc(4);
        pi_sclk  = 1'b0;
        wait_cyc(4);
    endtask

    task automatic pulse_sle;
        pi_sle = 1'b1;
        wait_cyc(4);
        pi_sle = 1'b0;
        wait_cyc(4);
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        wait_cyc(1);
    endtask

    typedef struct {
        logic [15:0] pat;
        int          nbits;
        logic [0:0]  rsel;
        int          toggle_at;
        bit          coinc;
        int          e_sh0;
        int          e_sh1;
        int          e_le0;
        int          e_le1;
        int          e_err;
        logic [15:0] e_pat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s_sh0, s_sh1, s_le0, s_le1, tot, lat;
        logic [15:0] mask;
        logic b;

        // Vectors: pattern is right-aligned and sent MSB-first.
        vecs[0] = '{16'h00A5, 8, 1'(REG_IDX_DATA), 0, 1'b0, 8, 0, 1, 0, 0, 16'h00A5};
        vecs[1] = '{16'h00A5, 8, 1'(REG_IDX_CTRL), 3, 1'b0, 0, 8, 0, 1, 0, 16'h00A5};
        vecs[2] = '{16'h001E, 7, 1'(REG_IDX_DATA), 0, 1'b0, 7, 0, 0, 0, 1, 16'h001E};
        vecs[3] = '{16'h012B, 9, 1'(REG_IDX_DATA), 0, 1'b0, 9, 0, 0, 0, 1, 16'h012B};
        vecs[4] = '{16'h00F0, 8, 1'(REG_IDX_DATA), 0, 1'b1, 7, 0, 0, 0, 1, 16'h0078};
        vecs[5] = '{16'h0000, 0, 1'(REG_IDX_DATA), 0, 1'b0, 0, 0, 0, 0, 1, 16'h0000};

        // Reset state
        wait_cyc(3);
        chk("rst_sh_en", int'(sh_en), 0);
        chk("rst_le", int'(le), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_din", int'(sh_din), 0);
        rst_n = 1'b1;
        wait_cyc(6);

        for (int v = 0; v < 6; v++) begin
            s_sh0 = n_sh0; s_sh1 = n_sh1; s_le0 = n_le0; s_le1 = n_le1;
            pi_rsel = vecs[v].rsel;
            for (int i = 0; i < vecs[v].nbits; i++) begin
                b = vecs[v].pat[vecs[v].nbits - 1 - i];
                pi_sdata = b;
                pi_sclk  = 1'b1;
                if (vecs[v].coinc && i == vecs[v].nbits - 1) pi_sle = 1'b1;
                wait_cyc(4);
                pi_sclk = 1'b0;
                pi_sle  = 1'b0;
                wait_cyc(4);
                if (i == 0) chk($sformatf("v%0d_busy_mid", v), int'(busy), 1);
                if (vecs[v].toggle_at != 0 && i + 1 == vecs[v].toggle_at)
                    pi_rsel = ~vecs[v].rsel;
            end
            if (!vecs[v].coinc) pulse_sle;
            wait_cyc(6);
            chk($sformatf("v%0d_sh0", v), n_sh0 - s_sh0, vecs[v].e_sh0);
            chk($sformatf("v%0d_sh1", v), n_sh1 - s_sh1, vecs[v].e_sh1);
            chk($sformatf("v%0d_le0", v), n_le0 - s_le0, vecs[v].e_le0);
            chk($sformatf("v%0d_le1", v), n_le1 - s_le1, vecs[v].e_le1);
            chk($sformatf("v%0d_err", v), int'(frame_err), vecs[v].e_err);
            chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
            tot  = (n_sh0 - s_sh0) + (n_sh1 - s_sh1);
            mask = 16'((32'd1 << tot) - 1);
            chk($sformatf("v%0d_bits", v), int'(rec & mask), int'(vecs[v].e_pat));
            pulse_clr;
            chk($sformatf("v%0d_err_clr", v), int'(frame_err), 0);
        end

        // clr_err coinciding with a new error: set wins
        pi_sle = 1'b1;
        wait_cyc(2);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        chk("set_beats_clr", int'(frame_err), 1);
        pi_sle = 1'b0;
        wait_cyc(4);
        pulse_clr;

        // Reset mid-frame with sclk held high through release
        s_sh0 = n_sh0; s_le0 = n_le0;
        pi_rsel = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("mid_busy", int'(busy), 1);
        pi_sclk = 1'b1;
        rst_n   = 1'b0;
        wait_cyc(3);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sh_en", int'(sh_en), 0);
        rst_n = 1'b1;
        wait_cyc(10);
        chk("midrst_spurious_sh", n_sh0 - s_sh0, 4);
        chk("midrst_no_le", n_le0 - s_le0, 0);
        chk("midrst_busy_after", int'(busy), 0);
        pi_sclk = 1'b0;
        wait_cyc(4);

        // Post-reset frame 0xC3 with latency measured on the first bit
        s_sh0 = n_sh0; s_sh1 = n_sh1; s_le0 = n_le0; s_le1 = n_le1;
        pi_sdata = 1'b1;
        pi_sclk  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sh_en != 2'b00) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 3);
        wait_cyc(2);
        pi_sclk = 1'b0;
        wait_cyc(4);
        for (int i = 6; i >= 0; i--) begin
            mask = 16'h00C3;
            send_bit(mask[i]);
        end
        pulse_sle;
        wait_cyc(6);
        chk("post_sh0", n_sh0 - s_sh0, 8);
        chk("post_sh1", n_sh1 - s_sh1, 0);
        chk("post_le0", n_le0 - s_le0, 1);
        chk("post_le1", n_le1 - s_le1, 0);
        chk("post_err", int'(frame_err), 0);
        chk("post_bits", int'(rec & 16'h00FF), 8'hC3);

        chk("mutual_exclusion", n_excl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
